// File: rtl/wbck_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wbck_pkg
// Brief    : Shared constants and the writeback request type for wbck_arb.
// Revision : 1.0 - initial release
// ============================================================================
package wbck_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;
    localparam int DEF_XLEN  = 32;

    // Data field is sized to the default datapath width used by wbck_arb.
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] idx;
        logic [DEF_XLEN-1:0]  dat;
    } wbck_req_t;

endpackage
`default_nettype wire

// File: rtl/wbck_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : wbck_scoreboard
// Brief    : Busy bit per architectural register for outstanding long-latency
//            writes; set on issue, cleared on writeback, set wins on collision.
// Revision : 1.0 - initial release
// ============================================================================
module wbck_scoreboard
    import wbck_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_set_valid,
    input  logic [REG_IDX_W-1:0] i_set_idx,
    input  logic                 i_clr_valid,
    input  logic [REG_IDX_W-1:0] i_clr_idx,
    output logic [NUM_REGS-1:0]  o_busy_vec
);

    assign o_busy_vec[0] = 1'b0;

    for (genvar n = 1; n < NUM_REGS; n++) begin : g_bit
        logic r_busy;
        logic w_set;
        logic w_clr;

        assign w_set = i_set_valid && (i_set_idx == REG_IDX_W'(n));
        assign w_clr = i_clr_valid && (i_clr_idx == REG_IDX_W'(n));

        // A new issue to the same register outranks the retiring writeback.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= w_set | (r_busy & ~w_clr);
            end
        end

        assign o_busy_vec[n] = r_busy;
    end

endmodule
`default_nettype wire

// File: rtl/wbck_arb.sv
`default_nettype none
// ============================================================================
// Module   : wbck_arb
// Brief    : Writeback arbiter (LSU/MDU over ALU with starvation guard),
//            registered register-file write port and long-latency scoreboard.
//            Optional forwarding ports under WBCK_ARB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wbck_arb
    import wbck_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int XLEN       = DEF_XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_wbck_valid,
    output logic                 alu_wbck_ready,
    input  logic [REG_IDX_W-1:0] alu_wbck_idx,
    input  logic [XLEN-1:0]      alu_wbck_dat,
    input  logic                 lsu_wbck_valid,
    output logic                 lsu_wbck_ready,
    input  logic [REG_IDX_W-1:0] lsu_wbck_idx,
    input  logic [XLEN-1:0]      lsu_wbck_dat,
    input  logic                 lsu_issue_valid,
    input  logic [REG_IDX_W-1:0] lsu_issue_idx,
    output logic [NUM_REGS-1:0]  busy_vec,
    output logic                 wbck_dest_wen,
    output logic [31:0]          wbck_dest_idx,
    output logic [XLEN-1:0]      wbck_dest_dat
`ifdef WBCK_ARB_BYPASS_EN
    ,
    output logic                 byp_valid,
    output logic [REG_IDX_W-1:0] byp_idx,
    output logic [XLEN-1:0]      byp_dat
`endif
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic                 w_alu_pri;
    logic                 w_alu_ready;
    logic                 w_lsu_ready;
    wbck_req_t            w_win;
    logic [3:0]           r_starve_cnt;
    logic                 r_wen;
    logic [REG_IDX_W-1:0] r_idx;
    logic [XLEN-1:0]      r_dat;

    // ALU wins a tie only once it has been refused STARVE_MAX cycles in a row.
    assign w_alu_pri   = (r_starve_cnt == c_starve_max);
    assign w_lsu_ready = lsu_wbck_valid & ~(w_alu_pri & alu_wbck_valid);
    assign w_alu_ready = alu_wbck_valid & (w_alu_pri | ~lsu_wbck_valid);

    assign alu_wbck_ready = w_alu_ready;
    assign lsu_wbck_ready = w_lsu_ready;

    always_comb begin
        w_win = '0;
        if (w_lsu_ready) begin
            w_win.valid = 1'b1;
            w_win.idx   = lsu_wbck_idx;
            w_win.dat   = lsu_wbck_dat;
        end else if (w_alu_ready) begin
            w_win.valid = 1'b1;
            w_win.idx   = alu_wbck_idx;
            w_win.dat   = alu_wbck_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!alu_wbck_valid || w_alu_ready) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != c_starve_max) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // x0 grants are consumed but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen <= 1'b0;
            r_idx <= '0;
            r_dat <= '0;
        end else if (w_win.valid) begin
            r_wen <= (w_win.idx != '0);
            r_idx <= w_win.idx;
            r_dat <= w_win.dat;
        end else begin
            r_wen <= 1'b0;
        end
    end

    assign wbck_dest_wen = r_wen;
    assign wbck_dest_idx = {{(32-REG_IDX_W){1'b0}}, r_idx};
    assign wbck_dest_dat = r_dat;

`ifdef WBCK_ARB_BYPASS_EN
    assign byp_valid = r_wen;
    assign byp_idx   = r_idx;
    assign byp_dat   = r_dat;
`endif

    wbck_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_set_valid (lsu_issue_valid),
        .i_set_idx   (lsu_issue_idx),
        .i_clr_valid (w_lsu_ready),
        .i_clr_idx   (lsu_wbck_idx),
        .o_busy_vec  (busy_vec)
    );

endmodule
`default_nettype wire

// File: tb/tb_wbck_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbck_arb
// Brief    : Directed self-checking bench for wbck_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wbck_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_wbck_valid = 1'b0;
    logic        alu_wbck_ready;
    logic [4:0]  alu_wbck_idx = '0;
    logic [31:0] alu_wbck_dat = '0;
    logic        lsu_wbck_valid = 1'b0;
    logic        lsu_wbck_ready;
    logic [4:0]  lsu_wbck_idx = '0;
    logic [31:0] lsu_wbck_dat = '0;
    logic        lsu_issue_valid = 1'b0;
    logic [4:0]  lsu_issue_idx = '0;
    logic [31:0] busy_vec;
    logic        wbck_dest_wen;
    logic [31:0] wbck_dest_idx;
    logic [31:0] wbck_dest_dat;
`ifdef WBCK_ARB_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_idx;
    logic [31:0] byp_dat;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wbck_arb #(.STARVE_MAX(3), .XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_wbck_valid  (alu_wbck_valid),
        .alu_wbck_ready  (alu_wbck_ready),
        .alu_wbck_idx    (alu_wbck_idx),
        .alu_wbck_dat    (alu_wbck_dat),
        .lsu_wbck_valid  (lsu_wbck_valid),
        .lsu_wbck_ready  (lsu_wbck_ready),
        .lsu_wbck_idx    (lsu_wbck_idx),
        .lsu_wbck_dat    (lsu_wbck_dat),
        .lsu_issue_valid (lsu_issue_valid),
        .lsu_issue_idx   (lsu_issue_idx),
        .busy_vec        (busy_vec),
        .wbck_dest_wen   (wbck_dest_wen),
        .wbck_dest_idx   (wbck_dest_idx),
        .wbck_dest_dat   (wbck_dest_dat)
`ifdef WBCK_ARB_BYPASS_EN
        ,
        .byp_valid       (byp_valid),
        .byp_idx         (byp_idx),
        .byp_dat         (byp_dat)
`endif
    );

    task automatic idle_inputs();
        alu_wbck_valid  = 1'b0;
        lsu_wbck_valid  = 1'b0;
        lsu_issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (wbck_dest_wen !== 1'b0 || wbck_dest_idx !== 32'd0 || wbck_dest_dat !== 32'd0) begin
            errors++;
            $display("FAIL reset_out: wen=%b idx=%h dat=%h expected 0/0/0", wbck_dest_wen, wbck_dest_idx, wbck_dest_dat);
        end
        checks++;
        if (busy_vec !== 32'd0) begin
            errors++;
            $display("FAIL reset_busy: got %h expected 0", busy_vec);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_single();
        alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd5; alu_wbck_dat = 32'h1234;
        #1;
        checks++;
        if (alu_wbck_ready !== 1'b1) begin
            errors++;
            $display("FAIL alu_single_ready: got %b expected 1", alu_wbck_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (wbck_dest_wen !== 1'b1 || wbck_dest_idx !== 32'd5 || wbck_dest_dat !== 32'h00001234) begin
            errors++;
            $display("FAIL alu_single_write: wen=%b idx=%h dat=%h expected 1/5/00001234", wbck_dest_wen, wbck_dest_idx, wbck_dest_dat);
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        checks++;
        if (wbck_dest_wen !== 1'b0 || wbck_dest_idx !== 32'd5 || wbck_dest_dat !== 32'h00001234) begin
            errors++;
            $display("FAIL alu_single_idle: wen=%b idx=%h dat=%h expected 0/5/00001234 (held)", wbck_dest_wen, wbck_dest_idx, wbck_dest_dat);
        end
        @(negedge clk);
    endtask

    task automatic test_both_valid();
        alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd3; alu_wbck_dat = 32'hA;
        lsu_wbck_valid = 1'b1; lsu_wbck_idx = 5'd4; lsu_wbck_dat = 32'hB;
        #1;
        checks++;
        if (lsu_wbck_ready !== 1'b1 || alu_wbck_ready !== 1'b0) begin
            errors++;
            $display("FAIL both_ready: lsu=%b alu=%b expected 1/0", lsu_wbck_ready, alu_wbck_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (wbck_dest_wen !== 1'b1 || wbck_dest_idx !== 32'd4 || wbck_dest_dat !== 32'hB) begin
            errors++;
            $display("FAIL both_lsu_write: wen=%b idx=%h dat=%h expected 1/4/b", wbck_dest_wen, wbck_dest_idx, wbck_dest_dat);
        end
        @(negedge clk);
        lsu_wbck_valid = 1'b0;
        #1;
        checks++;
        if (alu_wbck_ready !== 1'b1) begin
            errors++;
            $display("FAIL both_alu_ready: got %b expected 1", alu_wbck_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (wbck_dest_wen !== 1'b1 || wbck_dest_idx !== 32'd3 || wbck_dest_dat !== 32'hA) begin
            errors++;
            $display("FAIL both_alu_write: wen=%b idx=%h dat=%h expected 1/3/a", wbck_dest_wen, wbck_dest_idx, wbck_dest_dat);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_starvation();
        // Expected winner per cycle: L L L A L
        logic [4:0] exp_idx [5] = '{5'd7, 5'd7, 5'd7, 5'd8, 5'd7};
        alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd8; alu_wbck_dat = 32'h8888;
        lsu_wbck_valid = 1'b1; lsu_wbck_idx = 5'd7; lsu_wbck_dat = 32'h7777;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (alu_wbck_ready !== (exp_idx[i] == 5'd8) || lsu_wbck_ready !== (exp_idx[i] == 5'd7)) begin
                errors++;
                $display("FAIL starve_ready[%0d]: alu=%b lsu=%b expected winner x%0d", i, alu_wbck_ready, lsu_wbck_ready, exp_idx[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (wbck_dest_wen !== 1'b1 || wbck_dest_idx !== {27'd0, exp_idx[i]}) begin
                errors++;
                $display("FAIL starve_write[%0d]: wen=%b idx=%h expected 1/%h", i, wbck_dest_wen, wbck_dest_idx, exp_idx[i]);
            end
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            alu_wbck_valid = 1'b1;
            alu_wbck_idx   = 5'(10 + i);
            alu_wbck_dat   = 32'hC0DE_0000 + 32'(i);
            @(posedge clk); #1;
            checks++;
            if (wbck_dest_wen !== 1'b1 || wbck_dest_idx !== 32'(10 + i) || wbck_dest_dat !== 32'hC0DE_0000 + 32'(i)) begin
                errors++;
                $display("FAIL b2b[%0d]: wen=%b idx=%h dat=%h expected 1/%h/%h", i, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, 10 + i, 32'hC0DE_0000 + 32'(i));
            end
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_scoreboard();
        lsu_issue_valid = 1'b1; lsu_issue_idx = 5'd9;
        @(posedge clk); #1;
        checks++;
        if (busy_vec !== 32'h0000_0200) begin
            errors++;
            $display("FAIL sb_set: got %h expected 00000200", busy_vec);
        end
        @(negedge clk);
        lsu_wbck_valid = 1'b1; lsu_wbck_idx = 5'd9; lsu_wbck_dat = 32'h99;
        @(posedge clk); #1;
        checks++;
        if (busy_vec !== 32'h0000_0200) begin
            errors++;
            $display("FAIL sb_collide: got %h expected 00000200", busy_vec);
        end
        @(negedge clk);
        lsu_issue_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy_vec !== 32'h0000_0000) begin
            errors++;
            $display("FAIL sb_clear: got %h expected 00000000", busy_vec);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_x0();
        alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd0; alu_wbck_dat = 32'hFFFF_FFFF;
        lsu_issue_valid = 1'b1; lsu_issue_idx = 5'd0;
        #1;
        checks++;
        if (alu_wbck_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got %b expected 1", alu_wbck_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (wbck_dest_wen !== 1'b0) begin
            errors++;
            $display("FAIL x0_wen: got %b expected 0", wbck_dest_wen);
        end
        checks++;
        if (busy_vec !== 32'd0) begin
            errors++;
            $display("FAIL x0_busy: got %h expected 0", busy_vec);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        lsu_issue_valid = 1'b1; lsu_issue_idx = 5'd4;
        @(negedge clk);
        lsu_issue_idx  = 5'd5;
        alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd6; alu_wbck_dat = 32'h66;
        @(posedge clk); #1;
        checks++;
        if (busy_vec !== 32'h0000_0030 || wbck_dest_wen !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: busy=%h wen=%b expected 00000030/1", busy_vec, wbck_dest_wen);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_vec !== 32'd0 || wbck_dest_wen !== 1'b0) begin
            errors++;
            $display("FAIL arst_async: busy=%h wen=%b expected 0/0", busy_vec, wbck_dest_wen);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy_vec !== 32'd0 || wbck_dest_wen !== 1'b0 || wbck_dest_idx !== 32'd0) begin
            errors++;
            $display("FAIL arst_post: busy=%h wen=%b idx=%h expected 0/0/0", busy_vec, wbck_dest_wen, wbck_dest_idx);
        end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_both_valid();
        test_starvation();
        test_back_to_back();
        test_scoreboard();
        test_x0();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
